// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch controller:
//   - fun3_t                : branch condition encoding carried by decode
//   - state_t               : controller FSM states
//   - FLUSH_CYCLES_DEFAULT  : default number of flush cycles after a redirect
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        F_BEQ  = 3'b000,
        F_BNE  = 3'b001,
        F_RSV2 = 3'b010,
        F_RSV3 = 3'b011,
        F_BLT  = 3'b100,
        F_BGE  = 3'b101,
        F_BLTU = 3'b110,
        F_BGEU = 3'b111
    } fun3_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

endpackage

// File: rtl/branch_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
// Purely combinational branch condition evaluator.
// Ports:
//   rs1, rs2 (in, 32)  compare operands
//   fun3     (in, 3)   branch condition
//   taken    (out, 1)  condition holds
//   illegal  (out, 1)  fun3 is 010 or 011 (resolves not-taken)
// -----------------------------------------------------------------------------
module branch_cmp
    import branch_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  fun3,
    output logic        taken,
    output logic        illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (fun3)
            F_BEQ:   taken = eq;
            F_BNE:   taken = !eq;
            F_BLT:   taken = lt_s;
            F_BGE:   taken = !lt_s;
            F_BLTU:  taken = lt_u;
            F_BGEU:  taken = !lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Resolves one branch at a time: accepts a request in IDLE, evaluates it the
// next cycle, and on a mispredict steers fetch (REDIRECT) and squashes younger
// stages for FLUSH_CYCLES cycles.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; req_valid seen in any other state is ignored
// and the requester keeps it asserted until it is accepted.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake from decode
//   fun3, rs1, rs2    branch condition and operands
//   pc, imm           branch PC and sign-extended offset
//   pred_taken        fetch-stage prediction
//   resp_valid/taken  resolved outcome, one-cycle pulse
//   illegal           fun3 010/011, pulses with resp_valid
//   redirect_valid/pc fetch steering on mispredict; pc holds otherwise
//   flush             squash younger stages
//   fsm_state         current FSM state (observability)
//   stat_branches, stat_mispredicts  saturating counters, only when
//                     BRANCH_STATS_EN is defined
// Optional feature macro: BRANCH_STATS_EN
// -----------------------------------------------------------------------------
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  fun3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        pred_taken,
    output logic        resp_valid,
    output logic        resp_taken,
    output logic        illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output state_t      fsm_state
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
`endif
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t      state;
    state_t      state_next;

    logic [2:0]  fun3_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic        pred_q;
    logic [3:0]  flush_cnt;
    logic [31:0] redirect_pc_q;

    logic        cmp_taken;
    logic        cmp_illegal;
    logic        load_ops;
    logic        load_redirect;
    logic [31:0] target;

    branch_cmp u_cmp (
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .fun3    (fun3_q),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // 32-bit adds wrap naturally; the carry out is discarded.
    assign target = cmp_taken ? (pc_q + imm_q) : (pc_q + 32'd4);

    // Outputs are gated by rst so an in-flight operation emits nothing
    // while reset is held.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_taken     = 1'b0;
        illegal        = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        load_ops       = 1'b0;
        load_redirect  = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        load_ops   = 1'b1;
                        state_next = S_EVAL;
                    end
                end
                S_EVAL: begin
                    resp_valid = 1'b1;
                    resp_taken = cmp_taken;
                    illegal    = cmp_illegal;
                    if (cmp_taken != pred_q) begin
                        load_redirect = 1'b1;
                        state_next    = S_REDIRECT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    redirect_valid = 1'b1;
                    state_next     = S_FLUSH;
                end
                S_FLUSH: begin
                    flush = 1'b1;
                    // Last flush cycle when the counter reaches 1.
                    if (flush_cnt <= 4'd1) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fun3_q <= 3'd0;
            rs1_q  <= 32'd0;
            rs2_q  <= 32'd0;
            pc_q   <= 32'd0;
            imm_q  <= 32'd0;
            pred_q <= 1'b0;
        end else if (load_ops) begin
            fun3_q <= fun3;
            rs1_q  <= rs1;
            rs2_q  <= rs2;
            pc_q   <= pc;
            imm_q  <= imm;
            pred_q <= pred_taken;
        end
    end

    // Target is latched on the EVAL->REDIRECT edge and then held until the
    // next mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc_q <= 32'd0;
        end else if (load_redirect) begin
            redirect_pc_q <= target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= 4'd0;
        end else if (state == S_REDIRECT) begin
            flush_cnt <= FLUSH_INIT;
        end else if (state == S_FLUSH && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    assign redirect_pc = redirect_pc_q;
    assign fsm_state   = state;

`ifdef BRANCH_STATS_EN
    logic [15:0] branches_q;
    logic [15:0] mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q    <= 16'd0;
            mispredicts_q <= 16'd0;
        end else begin
            if (resp_valid && branches_q != 16'hFFFF) begin
                branches_q <= branches_q + 16'd1;
            end
            if (load_redirect && mispredicts_q != 16'hFFFF) begin
                mispredicts_q <= mispredicts_q + 16'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`endif

endmodule
